// File: rtl/d_phy_hs_lane_sequencer.sv
// d_phy_hs_lane_sequencer
//   Per-lane D-PHY master HS transmit sequencer. Takes one packet's byte
//   stream from the adapter layer and walks the lane through a full burst:
//   LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync -> payload -> trail -> LP-11.
//   All timing is counted in hs_clk cycles.
// Ports
//   i_hs_clk    byte clock
//   i_rst       synchronous, active-high reset
//   i_enable    lane enable, only looked at while idle
//   i_s_data    payload byte from adapter
//   i_s_valid   i_s_data valid
//   i_s_last    i_s_data is the last byte of the burst
//   o_s_ready   byte accepted on an edge where valid & ready (state decode only)
//   o_lp_dp     LP driver, Dp
//   o_lp_dn     LP driver, Dn
//   o_hs_en     HS driver enable
//   o_hs_data   HS byte, LSB first on the wire
//   o_busy      sequencer not idle
//   o_underrun  one-cycle pulse when payload ran dry before s_last
module d_phy_hs_lane_sequencer #(
  parameter int unsigned T_LPX      = 2,
  parameter int unsigned T_HS_PREP  = 2,
  parameter int unsigned T_HS_ZERO  = 4,
  parameter int unsigned T_HS_TRAIL = 3,
  parameter int unsigned T_HS_EXIT  = 3,
  parameter logic [7:0]  SYNC_BYTE  = 8'hB8
) (
  input  logic       i_hs_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic [7:0] i_s_data,
  input  logic       i_s_valid,
  input  logic       i_s_last,
  output logic       o_s_ready,
  output logic       o_lp_dp,
  output logic       o_lp_dn,
  output logic       o_hs_en,
  output logic [7:0] o_hs_data,
  output logic       o_busy,
  output logic       o_underrun
);

  localparam int unsigned M1   = (T_LPX > T_HS_PREP) ? T_LPX : T_HS_PREP;
  localparam int unsigned M2   = (M1 > T_HS_ZERO) ? M1 : T_HS_ZERO;
  localparam int unsigned M3   = (M2 > T_HS_TRAIL) ? M2 : T_HS_TRAIL;
  localparam int unsigned MAXP = (M3 > T_HS_EXIT) ? M3 : T_HS_EXIT;
  localparam int unsigned CW   = $clog2(MAXP) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LPX, S_PREP, S_ZERO, S_SYNC, S_PAYLOAD, S_TRAIL, S_EXIT
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_data_q;
  logic            r_last_q;
  logic            r_tb;
  logic            r_lp_dp;
  logic            r_lp_dn;
  logic            r_hs_en;
  logic [7:0]      r_hs_data;
  logic            r_busy;
  logic            r_underrun;

  state_t          w_nxt;
  logic            w_done;
  logic            w_xfer;
  logic            w_starve;
  logic            w_tb;

  // Down-counter reload value for the first cycle of each timed state.
  function automatic logic [CW-1:0] f_load(input state_t s);
    case (s)
      S_LPX:   f_load = CW'(T_LPX - 1);
      S_PREP:  f_load = CW'(T_HS_PREP - 1);
      S_ZERO:  f_load = CW'(T_HS_ZERO - 1);
      S_TRAIL: f_load = CW'(T_HS_TRAIL - 1);
      S_EXIT:  f_load = CW'(T_HS_EXIT - 1);
      default: f_load = '0;
    endcase
  endfunction

  assign o_s_ready = (r_state == S_SYNC) || ((r_state == S_PAYLOAD) && !r_last_q);
  assign w_xfer    = i_s_valid && o_s_ready;
  assign w_starve  = o_s_ready && !i_s_valid;
  assign w_done    = (r_cnt == '0);

  // Trail polarity follows the byte currently on the wire; SYNC counts as
  // the last driven byte when no payload was ever taken.
  always_comb begin
    w_tb = r_tb;
    if (r_state == S_SYNC)         w_tb = SYNC_BYTE[7];
    else if (r_state == S_PAYLOAD) w_tb = r_data_q[7];
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:    if (i_enable && i_s_valid) w_nxt = S_LPX;
      S_LPX:     if (w_done) w_nxt = S_PREP;
      S_PREP:    if (w_done) w_nxt = S_ZERO;
      S_ZERO:    if (w_done) w_nxt = S_SYNC;
      S_SYNC:    w_nxt = i_s_valid ? S_PAYLOAD : S_TRAIL;
      S_PAYLOAD: if (r_last_q || !i_s_valid) w_nxt = S_TRAIL;
      S_TRAIL:   if (w_done) w_nxt = S_EXIT;
      S_EXIT:    if (w_done) w_nxt = S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge i_hs_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_data_q   <= '0;
      r_last_q   <= 1'b0;
      r_tb       <= 1'b0;
      r_lp_dp    <= 1'b1;
      r_lp_dn    <= 1'b1;
      r_hs_en    <= 1'b0;
      r_hs_data  <= '0;
      r_busy     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_busy     <= (w_nxt != S_IDLE);
      r_underrun <= w_starve;
      r_tb       <= w_tb;
      if (w_nxt != r_state) r_cnt <= f_load(w_nxt);
      else if (!w_done)     r_cnt <= r_cnt - 1'b1;
      if (w_xfer) begin
        r_data_q <= i_s_data;
        r_last_q <= i_s_last;
      end
      case (w_nxt)
        S_LPX: begin
          r_lp_dp <= 1'b0; r_lp_dn <= 1'b1; r_hs_en <= 1'b0; r_hs_data <= '0;
        end
        S_PREP: begin
          r_lp_dp <= 1'b0; r_lp_dn <= 1'b0; r_hs_en <= 1'b0; r_hs_data <= '0;
        end
        S_ZERO: begin
          r_lp_dp <= 1'b0; r_lp_dn <= 1'b0; r_hs_en <= 1'b1; r_hs_data <= '0;
        end
        S_SYNC: begin
          r_lp_dp <= 1'b0; r_lp_dn <= 1'b0; r_hs_en <= 1'b1; r_hs_data <= SYNC_BYTE;
        end
        S_PAYLOAD: begin
          // PAYLOAD is only ever entered or held on a transfer.
          r_lp_dp <= 1'b0; r_lp_dn <= 1'b0; r_hs_en <= 1'b1; r_hs_data <= i_s_data;
        end
        S_TRAIL: begin
          r_lp_dp <= 1'b0; r_lp_dn <= 1'b0; r_hs_en <= 1'b1; r_hs_data <= {8{~w_tb}};
        end
        default: begin
          r_lp_dp <= 1'b1; r_lp_dn <= 1'b1; r_hs_en <= 1'b0; r_hs_data <= '0;
        end
      endcase
    end
  end

  assign o_lp_dp    = r_lp_dp;
  assign o_lp_dn    = r_lp_dn;
  assign o_hs_en    = r_hs_en;
  assign o_hs_data  = r_hs_data;
  assign o_busy     = r_busy;
  assign o_underrun = r_underrun;

endmodule

// File: tb/tb_d_phy_hs_lane_sequencer.sv
// Bench for d_phy_hs_lane_sequencer: builds the expected per-cycle lane
// trace of each burst from the packet contents and timing parameters, then
// plays an adapter against the DUT and compares every cycle.
module tb_d_phy_hs_lane_sequencer;

  localparam int unsigned T_LPX      = 2;
  localparam int unsigned T_HS_PREP  = 2;
  localparam int unsigned T_HS_ZERO  = 4;
  localparam int unsigned T_HS_TRAIL = 3;
  localparam int unsigned T_HS_EXIT  = 3;
  localparam logic [7:0]  SYNC_BYTE  = 8'hB8;

  logic       clk = 1'b0;
  logic       rst, enable, s_valid, s_last;
  logic [7:0] s_data;
  logic       s_ready, lp_dp, lp_dn, hs_en, busy, underrun;
  logic [7:0] hs_data;

  d_phy_hs_lane_sequencer #(
    .T_LPX(T_LPX), .T_HS_PREP(T_HS_PREP), .T_HS_ZERO(T_HS_ZERO),
    .T_HS_TRAIL(T_HS_TRAIL), .T_HS_EXIT(T_HS_EXIT), .SYNC_BYTE(SYNC_BYTE)
  ) dut (
    .i_hs_clk(clk), .i_rst(rst), .i_enable(enable), .i_s_data(s_data),
    .i_s_valid(s_valid), .i_s_last(s_last), .o_s_ready(s_ready),
    .o_lp_dp(lp_dp), .o_lp_dn(lp_dn), .o_hs_en(hs_en), .o_hs_data(hs_data),
    .o_busy(busy), .o_underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       dp;
    logic       dn;
    logic       en;
    logic [7:0] d;
    logic       rdy;
    logic       bsy;
    logic       und;
  } obs_t;

  int checks = 0;
  int failures = 0;
  int gcyc = 0;
  logic [7:0] pkt[$];
  int   stall_k = 0;
  bit   early_next = 0;
  logic [7:0] early_b = '0;
  logic early_last = 1'b0;
  int   lpx_cyc = -1;
  int   hs_last_cyc = -1;

  function automatic obs_t mk(input logic dp, input logic dn, input logic en,
                              input logic [7:0] d, input logic rdy,
                              input logic bsy, input logic und);
    obs_t o;
    o.dp = dp; o.dn = dn; o.en = en; o.d = d; o.rdy = rdy; o.bsy = bsy; o.und = und;
    return o;
  endfunction

  // Called at the negedge of the IDLE cycle where the packet is first
  // offered; returns at the negedge after the last modelled cycle.
  task automatic run_burst(input string name);
    obs_t exp_q[$];
    obs_t got;
    int n, m, idx, exit_lo;
    bit stall, hs;
    logic [7:0] fill;
    n = pkt.size();
    stall = (stall_k > 0) && (stall_k < n);
    m = stall ? stall_k : n;
    exp_q.push_back(mk(1, 1, 0, 8'h00, 0, 0, 0));
    for (int i = 0; i < T_LPX; i++)      exp_q.push_back(mk(0, 1, 0, 8'h00, 0, 1, 0));
    for (int i = 0; i < T_HS_PREP; i++)  exp_q.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0));
    for (int i = 0; i < T_HS_ZERO; i++)  exp_q.push_back(mk(0, 0, 1, 8'h00, 0, 1, 0));
    exp_q.push_back(mk(0, 0, 1, SYNC_BYTE, 1, 1, 0));
    for (int i = 0; i < m; i++)          exp_q.push_back(mk(0, 0, 1, pkt[i], (i != n - 1), 1, 0));
    fill = pkt[m-1][7] ? 8'h00 : 8'hFF;
    for (int i = 0; i < T_HS_TRAIL; i++) exp_q.push_back(mk(0, 0, 1, fill, 0, 1, stall && (i == 0)));
    exit_lo = exp_q.size();
    for (int i = 0; i < T_HS_EXIT; i++)  exp_q.push_back(mk(1, 1, 0, 8'h00, 0, 1, 0));
    if (!early_next) exp_q.push_back(mk(1, 1, 0, 8'h00, 0, 0, 0));

    idx = 0; hs = 0; lpx_cyc = -1;
    for (int c = 0; c < exp_q.size(); c++) begin
      gcyc++;
      if (hs) idx++;
      got = {lp_dp, lp_dn, hs_en, hs_data, s_ready, busy, underrun};
      checks++;
      if (got !== exp_q[c]) begin
        failures++;
        $display("FAIL %s cyc=%0d got dp=%b dn=%b en=%b d=%h rdy=%b busy=%b und=%b exp dp=%b dn=%b en=%b d=%h rdy=%b busy=%b und=%b",
                 name, c, got.dp, got.dn, got.en, got.d, got.rdy, got.bsy, got.und,
                 exp_q[c].dp, exp_q[c].dn, exp_q[c].en, exp_q[c].d, exp_q[c].rdy, exp_q[c].bsy, exp_q[c].und);
      end
      if (lp_dp === 1'b0 && lp_dn === 1'b1 && lpx_cyc < 0) lpx_cyc = gcyc;
      if (hs_en === 1'b1) hs_last_cyc = gcyc;
      enable = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (early_next && c >= exit_lo) begin
        s_valid = 1'b1; s_data = early_b; s_last = early_last;
      end else begin
        s_valid = (idx < m);
        s_data  = (idx < n) ? pkt[idx] : 8'h00;
        s_last  = (idx == n - 1);
      end
      hs = s_valid && (s_ready === 1'b1);
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic rand_pkt(input int n);
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({lp_dp, lp_dn} !== 2'b11) begin failures++; $display("FAIL reset_lp got=%b exp=11", {lp_dp, lp_dn}); end
    checks++; if (hs_en !== 1'b0) begin failures++; $display("FAIL reset_hs_en got=%b exp=0", hs_en); end
    checks++; if (hs_data !== 8'h00) begin failures++; $display("FAIL reset_hs_data got=%h exp=00", hs_data); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
  endtask

  task automatic test_basic_three_byte;
    pkt = '{8'h11, 8'h22, 8'h33};
    stall_k = 0; early_next = 0;
    run_burst("basic3");
  endtask

  task automatic test_one_byte;
    pkt = '{8'h80};
    stall_k = 0; early_next = 0;
    run_burst("one_byte");
  endtask

  task automatic test_underrun;
    rand_pkt(4);
    stall_k = 2; early_next = 0;
    run_burst("underrun_k2");
    for (int r = 0; r < 4; r++) begin
      rand_pkt(int'($urandom_range(2, 7)));
      stall_k = int'($urandom_range(1, pkt.size() - 1));
      run_burst("underrun_rand");
    end
    stall_k = 0;
  endtask

  task automatic test_reset_mid_burst;
    enable = 1'b1; s_valid = 1'b1; s_last = 1'b0; s_data = 8'($urandom_range(0, 255));
    repeat (2 + T_LPX + T_HS_PREP + T_HS_ZERO) @(negedge clk);
    checks++;
    if (hs_en !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL mid_burst_active got hs_en=%b busy=%b exp 1 1", hs_en, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({lp_dp, lp_dn, hs_en, busy, s_ready} !== 5'b11000) begin
      failures++;
      $display("FAIL reset_abort got dp=%b dn=%b en=%b busy=%b rdy=%b exp 1 1 0 0 0",
               lp_dp, lp_dn, hs_en, busy, s_ready);
    end
    rst = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    rand_pkt(3);
    run_burst("after_reset");
  endtask

  task automatic test_enable_gate;
    int wait_n;
    rand_pkt(2);
    wait_n = int'($urandom_range(5, 15));
    enable = 1'b0; s_valid = 1'b1; s_data = pkt[0]; s_last = 1'b0;
    for (int i = 0; i < wait_n; i++) begin
      @(negedge clk);
      checks++;
      if ({lp_dp, lp_dn, hs_en, busy, s_ready} !== 5'b11000) begin
        failures++;
        $display("FAIL enable_gate cyc=%0d got dp=%b dn=%b en=%b busy=%b rdy=%b exp 1 1 0 0 0",
                 i, lp_dp, lp_dn, hs_en, busy, s_ready);
      end
    end
    stall_k = 0; early_next = 0;
    run_burst("enable_gate");
  endtask

  task automatic test_back_to_back;
    logic [7:0] second[$];
    int trail_end;
    rand_pkt(int'($urandom_range(1, 4)));
    second = pkt;
    rand_pkt(int'($urandom_range(1, 5)));
    stall_k = 0; early_next = 1;
    early_b = second[0]; early_last = (second.size() == 1);
    run_burst("b2b_first");
    trail_end = hs_last_cyc;
    pkt = second; early_next = 0;
    run_burst("b2b_second");
    checks++;
    if (lpx_cyc - (trail_end + 1) != int'(T_HS_EXIT) + 1) begin
      failures++;
      $display("FAIL b2b_gap got=%0d exp=%0d", lpx_cyc - (trail_end + 1), T_HS_EXIT + 1);
    end
  endtask

  task automatic test_random_bursts;
    for (int r = 0; r < 20; r++) begin
      rand_pkt(int'($urandom_range(1, 8)));
      stall_k = ($urandom_range(0, 9) < 3 && pkt.size() > 1) ?
                int'($urandom_range(1, pkt.size() - 1)) : 0;
      early_next = 0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_burst("random");
    end
    stall_k = 0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    @(negedge clk);
    test_reset;
    test_basic_three_byte;
    test_one_byte;
    test_underrun;
    test_reset_mid_burst;
    test_enable_gate;
    test_back_to_back;
    test_random_bursts;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
